// File: rtl/wave_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wave_ram_arbiter
// Description : Sole master of the single-port 512x8 waveform sample RAM.
//               Capture writes (unthrottled pulses) are absorbed in a small
//               FIFO and drained into RAM slots not taken by display reads.
//               A read run-length limit and a full-buffer override guarantee
//               that buffered writes always drain.
//               Optional macro WBYPASS_EN: when the buffer is empty and no
//               read is pending, an incoming write goes straight to the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_ram_arbiter #(
   parameter int WBUF_DEPTH   = 4,
   parameter int MAX_READ_RUN = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_req,
   input  logic [8:0]                  wr_addr,
   input  logic [7:0]                  wr_data,
   input  logic                        rd_req,
   input  logic [8:0]                  rd_addr,
   output logic                        rd_grant,
   output logic                        rd_valid,
   output logic [7:0]                  rd_data,
   output logic [8:0]                  ram_addr,
   output logic                        ram_we,
   output logic [7:0]                  ram_wdata,
   input  logic [7:0]                  ram_rdata,
   output logic [$clog2(WBUF_DEPTH):0] wbuf_level
);

   localparam int c_PTR_W = $clog2(WBUF_DEPTH);
   localparam int c_LVL_W = c_PTR_W + 1;

   localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(WBUF_DEPTH);
   localparam logic [7:0]         c_RUN_MAX  = 8'(MAX_READ_RUN);

   // RAM slot kinds chosen each cycle
   localparam logic [1:0] c_SLOT_IDLE   = 2'd0;
   localparam logic [1:0] c_SLOT_READ   = 2'd1;
   localparam logic [1:0] c_SLOT_WRITE  = 2'd2;
   localparam logic [1:0] c_SLOT_BYPASS = 2'd3;

   // Write buffer storage and bookkeeping
   logic [8:0]         r_fifo_addr [WBUF_DEPTH];
   logic [7:0]         r_fifo_data [WBUF_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic [7:0]         r_run_cnt;

   // Read return pipeline
   logic               r_rd_pend;
   logic               r_rd_valid;
   logic [7:0]         r_rd_data;

   logic               w_empty;
   logic               w_full;
   logic               w_forced;
   logic [1:0]         w_slot;
   logic               w_push;
   logic               w_pop;
   logic [8:0]         w_head_addr;
   logic [7:0]         w_head_data;

   assign w_empty     = (r_level == '0);
   assign w_full      = (r_level == c_LVL_FULL);
   assign w_forced    = w_full || (!w_empty && (r_run_cnt == c_RUN_MAX));
   assign w_head_addr = r_fifo_addr[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   // Slot arbitration: forced drain beats reads, reads beat opportunistic drain
   always_comb begin
      w_slot = c_SLOT_IDLE;
      if (reset) begin
         w_slot = c_SLOT_IDLE;
      end else if (w_forced) begin
         w_slot = c_SLOT_WRITE;
      end else if (rd_req) begin
         w_slot = c_SLOT_READ;
      end else if (!w_empty) begin
         w_slot = c_SLOT_WRITE;
`ifdef WBYPASS_EN
      end else if (wr_req) begin
         w_slot = c_SLOT_BYPASS;
`endif
      end
   end

   // A bypassed write never enters the buffer; a full buffer is always popped
   // in the same cycle, so pushes are never lost.
   assign w_push = wr_req && !reset && (w_slot != c_SLOT_BYPASS);
   assign w_pop  = (w_slot == c_SLOT_WRITE);

   // Drive the RAM port and read grant from the chosen slot
   always_comb begin
      rd_grant  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (w_slot)
         c_SLOT_READ: begin
            rd_grant = 1'b1;
            ram_addr = rd_addr;
         end
         c_SLOT_WRITE: begin
            ram_we    = 1'b1;
            ram_addr  = w_head_addr;
            ram_wdata = w_head_data;
         end
         c_SLOT_BYPASS: begin
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
         end
         default: ;
      endcase
   end

   // Buffer storage; a push into a full buffer reuses the slot being popped
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= wr_addr;
         r_fifo_data[r_wr_ptr] <= wr_data;
      end
   end

   // Buffer pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_pop && !w_push) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   // Count reads granted while writes are waiting; saturates at the limit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_run_cnt <= '0;
      end else if (w_pop || w_empty) begin
         r_run_cnt <= '0;
      end else if ((w_slot == c_SLOT_READ) && (r_run_cnt != c_RUN_MAX)) begin
         r_run_cnt <= r_run_cnt + 8'd1;
      end
   end

   // Two-stage read return; reset cancels anything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_pend  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_pend  <= rd_grant;
         r_rd_valid <= r_rd_pend;
         if (r_rd_pend) begin
            r_rd_data <= ram_rdata;
         end
      end
   end

   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign wbuf_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_wave_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_ram_arbiter
// Description : Directed self-checking bench for wave_ram_arbiter with
//               default parameters (WBUF_DEPTH=4, MAX_READ_RUN=8). Honours
//               WBYPASS_EN for the single-write latency expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_ram_arbiter;

   logic       clk;
   logic       reset;
   logic       wr_req;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_req;
   logic [8:0] rd_addr;
   logic       rd_grant;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [8:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic [2:0] wbuf_level;

   logic [7:0]  ram_mem [512];
   logic [16:0] wlog [$];

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   wave_ram_arbiter #(
      .WBUF_DEPTH   (4),
      .MAX_READ_RUN (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_grant   (rd_grant),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .wbuf_level (wbuf_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-only RAM model: data valid the cycle after the address
   always @(posedge clk) ram_rdata <= ram_mem[ram_addr];

   // Record every RAM write in the order the RAM sees it
   always @(negedge clk) if (ram_we === 1'b1) wlog.push_back({ram_addr, ram_wdata});

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are sampled 2 later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   int grants;
   int writes;
   int forced;
   int max_level;

   initial begin
      for (int i = 0; i < 512; i++) ram_mem[i] = 8'(i) ^ 8'h5A;
      ram_mem[9'h1A5] = 8'h3C;
      reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0;
      repeat (2) @(posedge clk);

      // ---------------- reset values ----------------
      step(); reset = 1'b0; settle();
      check("reset_level", 32'(wbuf_level), 0);
      check("reset_rd_valid", 32'(rd_valid), 0);
      check("reset_rd_data", 32'(rd_data), 0);

      // ---------------- reset mid-operation ----------------
      step(); rd_req = 1'b1; rd_addr = 9'h0AA; settle();
      check("pre_reset_grant", 32'(rd_grant), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         reset = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
         wr_addr = 9'h100 + 9'(i); wr_data = 8'h10 + 8'(i);
         settle();
         check("rst_rd_grant", 32'(rd_grant), 0);
         check("rst_ram_we", 32'(ram_we), 0);
         check("rst_ram_addr", 32'(ram_addr), 0);
         check("rst_rd_valid", 32'(rd_valid), 0);
      end
      step(); reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; settle();
      check("post_rst_level", 32'(wbuf_level), 0);
      check("post_rst_valid0", 32'(rd_valid), 0);
      step(); settle();
      check("post_rst_valid1", 32'(rd_valid), 0);
      check("post_rst_we", 32'(ram_we), 0);

      // ---------------- single read ----------------
      step(); rd_req = 1'b1; rd_addr = 9'h1A5; settle();
      check("rd_grant_N", 32'(rd_grant), 1);
      check("rd_ram_addr_N", 32'(ram_addr), 32'h1A5);
      check("rd_ram_we_N", 32'(ram_we), 0);
      step(); rd_req = 1'b0; settle();
      check("rd_valid_N1", 32'(rd_valid), 0);
      check("rd_grant_N1", 32'(rd_grant), 0);
      step(); settle();
      check("rd_valid_N2", 32'(rd_valid), 1);
      check("rd_data_N2", 32'(rd_data), 32'h3C);
      step(); settle();
      check("rd_valid_N3", 32'(rd_valid), 0);
      check("rd_data_hold", 32'(rd_data), 32'h3C);

      // ---------------- single write on idle bus ----------------
      step(); wr_req = 1'b1; wr_addr = 9'h100; wr_data = 8'h80; settle();
`ifdef WBYPASS_EN
      check("byp_we", 32'(ram_we), 1);
      check("byp_addr", 32'(ram_addr), 32'h100);
      check("byp_data", 32'(ram_wdata), 32'h80);
      step(); wr_req = 1'b0; settle();
      check("byp_level", 32'(wbuf_level), 0);
      check("byp_we_after", 32'(ram_we), 0);
`else
      check("buf_we_same", 32'(ram_we), 0);
      step(); wr_req = 1'b0; settle();
      check("buf_we_next", 32'(ram_we), 1);
      check("buf_addr", 32'(ram_addr), 32'h100);
      check("buf_data", 32'(ram_wdata), 32'h80);
      check("buf_level1", 32'(wbuf_level), 1);
`endif
      step(); settle();
      check("wr_level_done", 32'(wbuf_level), 0);
      check("wr_we_done", 32'(ram_we), 0);

      // ---------------- read run limit with 3 pending writes ----------------
      grants = 0;
      writes = 0;
      for (int c = 0; c < 60 && writes < 3; c++) begin
         step();
         rd_req  = 1'b1;
         rd_addr = 9'h005;
         wr_req  = (c >= 1 && c <= 3);
         wr_addr = 9'h1F0 + 9'(c);
         wr_data = 8'hA0 + 8'(c);
         settle();
         check("run_exclusive", 32'(rd_grant & ram_we), 0);
         if (rd_grant && wbuf_level != 0) grants++;
         if (ram_we) begin
            check("run_len", 32'(grants), 8);
            check("run_order", 32'({ram_addr, ram_wdata}),
                  32'({9'(9'h1F1 + 9'(writes)), 8'(8'hA1 + 8'(writes))}));
            grants = 0;
            writes++;
         end
      end
      check("run_writes", 32'(writes), 3);
      step(); wr_req = 1'b0; settle();
      check("run_level_empty", 32'(wbuf_level), 0);
      check("run_grant_after", 32'(rd_grant), 1);
      step(); rd_req = 1'b0; settle();
      step(); settle();

      // ---------------- continuous writes against continuous reads ----------------
      wlog.delete();
      forced = 0;
      max_level = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         rd_req = 1'b1; rd_addr = 9'h00C;
         wr_req = 1'b1; wr_addr = 9'h140 + 9'(i); wr_data = 8'h50 + 8'(i);
         settle();
         if (ram_we) forced++;
         if (int'(wbuf_level) > max_level) max_level = int'(wbuf_level);
      end
      step(); wr_req = 1'b0; rd_req = 1'b0; settle();
      for (int i = 0; i < 20 && wbuf_level != 0; i++) begin
         step(); settle();
      end
      check("burst_drained", 32'(wbuf_level), 0);
      check("burst_max_level", 32'(max_level), 4);
      check("burst_forced", 32'(forced), 6);
      check("burst_count", 32'(wlog.size()), 10);
      for (int i = 0; i < 10 && i < wlog.size(); i++) begin
         check("burst_order", 32'(wlog[i]), 32'({9'(9'h140 + 9'(i)), 8'(8'h50 + 8'(i))}));
      end

      // ---------------- simultaneous push and pop at level 2 ----------------
      step(); settle();
      wlog.delete();
      step(); rd_req = 1'b1; rd_addr = 9'h011;
      wr_req = 1'b1; wr_addr = 9'h1A1; wr_data = 8'hC1; settle();
      check("pp_grant0", 32'(rd_grant), 1);
      step(); wr_addr = 9'h1A2; wr_data = 8'hC2; settle();
      check("pp_level1", 32'(wbuf_level), 1);
      check("pp_grant1", 32'(rd_grant), 1);
      step(); rd_req = 1'b0; wr_addr = 9'h1A3; wr_data = 8'hC3; settle();
      check("pp_level2", 32'(wbuf_level), 2);
      check("pp_pop_head", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 9'h1A1, 8'hC1}));
      check("pp_valid_b2b0", 32'(rd_valid), 1);
      step(); wr_req = 1'b0; settle();
      check("pp_level_same", 32'(wbuf_level), 2);
      check("pp_valid_b2b1", 32'(rd_valid), 1);
      check("pp_second", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 9'h1A2, 8'hC2}));
      step(); settle();
      check("pp_level_drain", 32'(wbuf_level), 1);
      check("pp_valid_end", 32'(rd_valid), 0);
      step(); settle();
      check("pp_level_empty", 32'(wbuf_level), 0);
      check("pp_log_count", 32'(wlog.size()), 3);
      for (int i = 0; i < 3 && i < wlog.size(); i++) begin
         check("pp_log_order", 32'(wlog[i]), 32'({9'(9'h1A1 + 9'(i)), 8'(8'hC1 + 8'(i))}));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
